// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: memory waits, load-use,
// taken branches, multi-cycle mul/div occupancy and a saturating stall counter.
module pipeline_hazard_controller #(
    parameter int unsigned CNT_WIDTH         = 16,
    parameter int unsigned MULDIV_MAX_CYCLES = 34
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 imem_busywait,
    input  logic                 dmem_busywait,
    input  logic                 idex_mem_read,
    input  logic [4:0]           idex_rd,
    input  logic [4:0]           ifid_rs1,
    input  logic [4:0]           ifid_rs2,
    input  logic                 ifid_use_rs1,
    input  logic                 ifid_use_rs2,
    input  logic                 branch_taken,
    input  logic                 muldiv_start,
    input  logic                 muldiv_done,
    output logic                 stall_pc,
    output logic                 stall_ifid,
    output logic                 stall_idex,
    output logic                 stall_exmem,
    output logic                 stall_memwb,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic                 flush_exmem,
    output logic                 muldiv_timeout,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int unsigned CYC_W = $clog2(MULDIV_MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MULDIV = 2'd1
    } state_e;

    state_e               state_q, state_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d;
    logic [CYC_W-1:0]     cyc_inc;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 load_use;

    // Load in EX whose destination feeds a source operand of the ID instruction
    assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                      ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                       (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

    assign cyc_inc = cyc_q + CYC_W'(1);

    // Prioritised hazard resolution: control outputs and next-state values
    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        stall_memwb = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        state_d     = state_q;
        cyc_d       = cyc_q;
        timeout_d   = timeout_q;

        if (dmem_busywait) begin
            // Whole pipeline freezes; mul/div progress is frozen too
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            stall_memwb = 1'b1;
        end else if (state_q == ST_MULDIV) begin
            if (muldiv_done) begin
                state_d = ST_RUN;
                cyc_d   = '0;
            end else begin
                stall_pc    = 1'b1;
                stall_ifid  = 1'b1;
                stall_idex  = 1'b1;
                flush_exmem = 1'b1;
                if (cyc_inc == CYC_W'(MULDIV_MAX_CYCLES)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RUN;
                    cyc_d     = '0;
                end else begin
                    cyc_d = cyc_inc;
                end
            end
        end else if (branch_taken) begin
            // PC must load the target even while instruction memory is busy
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (muldiv_start) begin
            if (!muldiv_done) begin
                stall_pc    = 1'b1;
                stall_ifid  = 1'b1;
                stall_idex  = 1'b1;
                flush_exmem = 1'b1;
                state_d     = ST_MULDIV;
                cyc_d       = CYC_W'(1);
            end
        end else if (load_use) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (imem_busywait) begin
            stall_pc   = 1'b1;
            flush_ifid = 1'b1;
        end

        // Reset holds every stage in a bubble
        if (!reset) begin
            stall_pc    = 1'b0;
            stall_ifid  = 1'b0;
            stall_idex  = 1'b0;
            stall_exmem = 1'b0;
            stall_memwb = 1'b0;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
        end

        cnt_d = (stall_pc && (cnt_q != '1)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    // State, mul/div cycle counter, sticky timeout and stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            cyc_q     <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign state          = 2'(state_q);
    assign muldiv_timeout = timeout_q;
    assign stall_count    = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: behavioural reference model plus directed and random stimulus.
module tb_pipeline_hazard_controller;

    localparam int MAXC = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_busywait, dmem_busywait, idex_mem_read;
    logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
    logic        ifid_use_rs1, ifid_use_rs2;
    logic        branch_taken, muldiv_start, muldiv_done;
    logic        stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
    logic        flush_ifid, flush_idex, flush_exmem;
    logic        muldiv_timeout;
    logic [1:0]  state;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_busy;
    int m_used;
    bit m_to;
    int m_cnt;

    pipeline_hazard_controller #(.CNT_WIDTH(16), .MULDIV_MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset),
        .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .branch_taken(branch_taken), .muldiv_start(muldiv_start), .muldiv_done(muldiv_done),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .muldiv_timeout(muldiv_timeout), .state(state), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_busywait = 0; dmem_busywait = 0; idex_mem_read = 0;
        idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0; ifid_use_rs1 = 0; ifid_use_rs2 = 0;
        branch_taken = 0; muldiv_start = 0; muldiv_done = 0;
    endtask

    // Compare process: model predicts outputs from the rules, then advances one cycle
    always @(negedge clk) begin
        bit hz;
        bit [4:0] e_st;   // {pc, ifid, idex, exmem, memwb}
        bit [2:0] e_fl;   // {ifid, idex, exmem}
        bit n_busy, n_to;
        int n_used;
        if (!reset) begin
            m_busy = 0; m_used = 0; m_to = 0; m_cnt = 0;
            check("rst_stall", {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb}, 5'b00000);
            check("rst_flush", {flush_ifid, flush_idex, flush_exmem}, 3'b111);
            check("rst_state", state, 0);
            check("rst_timeout", muldiv_timeout, 0);
            check("rst_count", stall_count, 0);
        end else begin
            hz = idex_mem_read && idex_rd != 0 &&
                 ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
            e_st = '0; e_fl = '0;
            n_busy = m_busy; n_used = m_used; n_to = m_to;
            if (dmem_busywait) begin
                e_st = 5'b11111;
            end else if (m_busy) begin
                if (muldiv_done) begin
                    n_busy = 0; n_used = 0;
                end else begin
                    e_st = 5'b11100; e_fl = 3'b001;
                    n_used = m_used + 1;
                    if (n_used == MAXC) begin
                        n_to = 1; n_busy = 0; n_used = 0;
                    end
                end
            end else if (branch_taken) begin
                e_fl = 3'b110;
            end else if (muldiv_start) begin
                if (!muldiv_done) begin
                    e_st = 5'b11100; e_fl = 3'b001; n_busy = 1; n_used = 1;
                end
            end else if (hz) begin
                e_st = 5'b11000; e_fl = 3'b010;
            end else if (imem_busywait) begin
                e_st = 5'b10000; e_fl = 3'b100;
            end
            check("stalls", {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb}, 32'(e_st));
            check("flushes", {flush_ifid, flush_idex, flush_exmem}, 32'(e_fl));
            check("state", state, m_busy ? 1 : 0);
            check("timeout", muldiv_timeout, 32'(m_to));
            check("count", stall_count, m_cnt);
            if (e_st[4] && m_cnt < 65535) m_cnt++;
            m_busy = n_busy; m_used = n_used; m_to = n_to;
        end
    end

    initial begin
        int n;
        clear_inputs();
        reset = 0;
        repeat (3) tick();
        #2;
        check("lit_rst_flush", {flush_ifid, flush_idex, flush_exmem}, 3'b111);
        check("lit_rst_stall_pc", stall_pc, 0);
        tick();
        reset = 1;
        repeat (10) tick();
        check("lit_idle_state", state, 0);
        check("lit_idle_count", stall_count, 0);

        // Load-use on rs2
        idex_mem_read = 1; idex_rd = 5; ifid_rs2 = 5; ifid_use_rs2 = 1;
        #2;
        check("lit_loaduse", {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem}, 6'b110010);
        tick();
        clear_inputs();
        #2;
        check("lit_loaduse_cnt", stall_count, 1);
        check("lit_loaduse_gone", stall_pc, 0);

        // Mul/div completing on the 8th busy cycle
        tick();
        muldiv_start = 1;
        #2;
        check("lit_md_start", {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem}, 6'b111001);
        tick();
        muldiv_start = 0;
        check("lit_md_state", state, 1);
        repeat (7) tick();
        muldiv_done = 1;
        #2;
        check("lit_md_done_out", {stall_pc, stall_ifid, stall_idex, flush_exmem}, 4'b0000);
        check("lit_md_done_state", state, 1);
        tick();
        muldiv_done = 0;
        check("lit_md_back", state, 0);

        // Timeout: 33 busy cycles after the start cycle
        muldiv_start = 1;
        tick();
        muldiv_start = 0;
        n = 0;
        while (state == 2'd1 && n < 60) begin n++; tick(); end
        check("lit_to_len", n, 33);
        check("lit_to_flag", muldiv_timeout, 1);
        repeat (3) tick();
        check("lit_to_sticky", muldiv_timeout, 1);

        // Data-memory wait freezes mul/div progress; branch ignored while busy
        muldiv_start = 1;
        tick();
        muldiv_start = 0;
        n = 0;
        while (state == 2'd1 && n < 60) begin
            n++;
            if (n == 2) begin
                dmem_busywait = 1; branch_taken = 1;
                #2;
                check("lit_dmem_stall", {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb}, 5'b11111);
                check("lit_dmem_flush", {flush_ifid, flush_idex, flush_exmem}, 3'b000);
            end
            if (n == 5) dmem_busywait = 0;
            tick();
        end
        clear_inputs();
        check("lit_dmem_len", n, 36);

        // Branch beats imem wait and load-use
        branch_taken = 1; imem_busywait = 1; idex_mem_read = 1; idex_rd = 7; ifid_rs1 = 7; ifid_use_rs1 = 1;
        #2;
        check("lit_branch", {stall_pc, stall_ifid, flush_ifid, flush_idex}, 4'b0011);
        tick();
        clear_inputs();

        // Reset asserted mid mul/div
        muldiv_start = 1;
        tick();
        muldiv_start = 0;
        repeat (2) tick();
        #2;
        reset = 0;
        #1;
        check("lit_midrst_state", state, 0);
        check("lit_midrst_flush", {stall_pc, flush_ifid, flush_idex, flush_exmem}, 4'b0111);
        check("lit_midrst_to", muldiv_timeout, 0);
        tick();
        reset = 1;
        tick();

        // Randomised traffic
        repeat (3000) begin
            dmem_busywait = ($urandom_range(0, 9) == 0);
            imem_busywait = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 6) == 0);
            muldiv_start  = ($urandom_range(0, 9) == 0);
            muldiv_done   = ($urandom_range(0, 9) == 0);
            idex_mem_read = $urandom_range(0, 1) == 1;
            idex_rd       = 5'($urandom_range(0, 3));
            ifid_rs1      = 5'($urandom_range(0, 3));
            ifid_rs2      = 5'($urandom_range(0, 3));
            ifid_use_rs1  = $urandom_range(0, 1) == 1;
            ifid_use_rs2  = $urandom_range(0, 1) == 1;
            tick();
        end
        clear_inputs();
        repeat (40) tick();

        // Saturation of the stall counter
        imem_busywait = 1;
        repeat (65600) tick();
        check("lit_sat", stall_count, 65535);
        tick();
        check("lit_sat_hold", stall_count, 65535);
        imem_busywait = 0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
